// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, Booth digit codes and iteration count for the radix-4 multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;
  localparam int DEFAULT_WIDTH = 16;
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction
  localparam int ITER = iter_count(DEFAULT_WIDTH);
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]} to a radix-4 Booth digit
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);
  assign digit = (window == 3'b001 || window == 3'b010) ? POS1 :
                 (window == 3'b011)                     ? POS2 :
                 (window == 3'b100)                     ? NEG2 :
                 (window == 3'b101 || window == 3'b110) ? NEG1 : ZERO;
endmodule

// File: rtl/booth_r4_multiplier.sv
// booth_r4_multiplier: sequential radix-4 Booth multiplier, one digit per clock, start/busy/done handshake
module booth_r4_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int EW    = WIDTH + 2;
  localparam int NITER = (WIDTH == DEFAULT_WIDTH) ? ITER : iter_count(WIDTH);
  localparam int CW    = $clog2(NITER);
  mult_state_t     state, state_next;
  booth_digit_t    digit;
  logic [CW-1:0]   cnt;
  logic [EW-1:0]   mcand;
  logic [2*EW-1:0] acc, acc_next;
  logic            q_m1;
  logic [EW+1:0]   m_ext, pp, sum;
  // Two extra bits let one signed datapath cover unsigned operands as well
  function automatic logic [EW-1:0] ext(input logic [WIDTH-1:0] x, input logic s);
    return {{2{s & x[WIDTH-1]}}, x};
  endfunction
  booth_r4_encoder u_enc (
    .window({acc[1:0], q_m1}),
    .digit (digit)
  );
  assign m_ext = {{2{mcand[EW-1]}}, mcand};
  assign busy  = state == CALC;
  assign done  = state == DONE;
  // Upper half accumulates in EW+2 bits; dropping the top two after the shift is the arithmetic >>2
  always_comb begin
    pp = digit == POS1 ? m_ext :
         digit == POS2 ? m_ext << 1 :
         digit == NEG1 ? -m_ext :
         digit == NEG2 ? -(m_ext << 1) : '0;
    sum = {{2{acc[2*EW-1]}}, acc[2*EW-1:EW]} + pp;
    acc_next = {sum, acc[EW-1:2]};
  end
  always_comb begin
    state_next = state == IDLE ? (start ? CALC : IDLE) :
                 state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        mcand <= ext(multiplicand, signed_mode);
        acc   <= {{EW{1'b0}}, ext(multiplier, signed_mode)};
        q_m1  <= 1'b0;
        cnt   <= CW'(NITER - 1);
      end else if (state == CALC) begin
        acc  <= acc_next;
        q_m1 <= acc[1];
        cnt  <= cnt == '0 ? cnt : cnt - 1'b1;
        if (cnt == '0) product <= acc_next[2*WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_booth_r4_multiplier.sv
// tb_booth_r4_multiplier: directed and random checks of product, latency and handshake
module tb_booth_r4_multiplier;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [15:0] multiplicand = '0, multiplier = '0;
  logic        busy, done;
  logic [31:0] product;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  booth_r4_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // now=1 drives start at the very next falling edge (back-to-back after DONE)
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [31:0] exp, input string tag, input bit now);
    int n;
    if (!now) @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b; signed_mode = s;
    @(negedge clk);
    start = 1'b0; multiplicand = ~a; multiplier = ~b; signed_mode = ~s;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd9);
    chk(tag, product, exp);
    @(negedge clk);
    chk({tag, " pulse"}, 32'(done), 32'd0);
  endtask
  initial begin
    int dn;
    logic [31:0] p, ea, eb;
    logic [15:0] a, b;
    logic s;
    repeat (2) @(negedge clk);
    chk("reset product", product, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle busy/done", {30'b0, busy, done}, 32'd0);
      chk("idle product", product, 32'd0);
    end
    run(16'h0005, 16'h0003, 1'b0, 32'h0000000F, "u 5*3", 1'b0);
    run(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u max*max", 1'b0);
    run(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s -1*-1", 1'b0);
    run(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s min*min", 1'b0);
    run(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s min*1", 1'b0);
    run(16'h0000, 16'h1234, 1'b1, 32'h00000000, "s 0*x", 1'b0);
    run(16'h1234, 16'h0000, 1'b0, 32'h00000000, "u x*0", 1'b0);
    run(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, "s max*min", 1'b0);
    run(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "u max*2", 1'b0);
    run(16'h8000, 16'h8000, 1'b0, 32'h40000000, "u 8000*8000", 1'b0);
    run(16'h0064, 16'hFFF6, 1'b1, 32'hFFFFFC18, "s 100*-10", 1'b1);
    // start during CALC cycle 3 must be ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h0007; multiplier = 16'h0009; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h1234; multiplier = 16'h0002;
    @(negedge clk);
    start = 1'b0;
    dn = 0; p = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin dn++; p = product; end
    end
    chk("ignored start dones", 32'(dn), 32'd1);
    chk("ignored start product", p, 32'd63);
    chk("ignored start busy", 32'(busy), 32'd0);
    // asynchronous abort at CALC cycle 4
    start = 1'b1; multiplicand = 16'h0003; multiplier = 16'h0004;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort product", product, 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort no done", 32'(dn), 32'd0);
    run(16'h0003, 16'h0004, 1'b0, 32'h0000000C, "after abort", 1'b1);
    for (int i = 0; i < 1500; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      if (i % 50 == 0) a = 16'h8000;
      if (i % 70 == 0) b = 16'hFFFF;
      if (i % 90 == 0) a = 16'h0000;
      ea = s ? {{16{a[15]}}, a} : {16'b0, a};
      eb = s ? {{16{b[15]}}, b} : {16'b0, b};
      run(a, b, s, ea * eb, "random", 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
